bpu_resolve_queue: RTL and testbench

//  EX-side counterpart of the branch predictor. Fetch pushes one prediction record per predicted control

---
 rtl/bpu_resolve_queue.sv | 138 +++++++++++++
 tb/tb_bpu_resolve_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_resolve_queue.sv
// bpu_resolve_queue: in-order queue of fetch prediction records, checked against EX resolution.
// Defining BPU_PERF_CNT_EN adds resolve/mispredict performance counters.
module bpu_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_valid_i,
    output logic          push_ready_o,
    input  logic [AW-1:0] push_pc_i,
    input  logic [1:0]    push_type_i,
    input  logic          push_taken_i,
    input  logic [AW-1:0] push_target_i,
    input  logic          ex_valid_i,
    input  logic [AW-1:0] ex_pc_i,
    input  logic [1:0]    ex_type_i,
    input  logic          ex_taken_i,
    input  logic [AW-1:0] ex_target_i,
    input  logic          ex_link_i,
`ifdef BPU_PERF_CNT_EN
    output logic [31:0]   perf_resolve_o,
    output logic [31:0]   perf_mispredict_o,
`endif
    output logic [1:0]    ex_branch_type_o,
    output logic          ex_set_register_o,
    output logic [AW-1:0] ex_inst_addr_o,
    output logic          redirect_valid_o,
    output logic [AW-1:0] redirect_pc_o,
    output logic          orphan_o
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {RUN, RECOVER} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic [AW-1:0]   pc_mem [DEPTH];
    logic [AW-1:0]   target_mem [DEPTH];
    logic [1:0]      type_mem [DEPTH];
    logic            taken_mem [DEPTH];
    logic [1:0]      ex_branch_type_q, ex_branch_type_d;
    logic            ex_set_register_q, ex_set_register_d;
    logic [AW-1:0]   ex_inst_addr_q, ex_inst_addr_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [AW-1:0]   redirect_pc_q, redirect_pc_d;
    logic            orphan_q, orphan_d;
    logic            resolve, pop, orphan, mispredict, recover, push, clr, live;
`ifdef BPU_PERF_CNT_EN
    logic [31:0]     perf_resolve_q, perf_resolve_d, perf_mispredict_q, perf_mispredict_d;
`endif

    assign push_ready_o = (count_q < (PW+1)'(DEPTH)) && (state_q == RUN);

    always_comb begin
        resolve    = ex_valid_i && (state_q == RUN);
        pop        = resolve && (count_q != '0);
        orphan     = resolve && (count_q == '0);
        mispredict = pop && ((pc_mem[rd_ptr_q] != ex_pc_i) || (taken_mem[rd_ptr_q] != ex_taken_i)
                     || (ex_taken_i && (target_mem[rd_ptr_q] != ex_target_i))
                     || (type_mem[rd_ptr_q] != ex_type_i));
        recover    = mispredict || orphan;
        // A push racing a redirect belongs to the wrong path and is dropped.
        push       = push_valid_i && push_ready_o && !recover && !flush_i;
        clr        = flush_i || recover;
        live       = resolve && !flush_i;
        rd_ptr_d   = clr ? '0 : rd_ptr_q + PW'(pop);
        wr_ptr_d   = clr ? '0 : wr_ptr_q + PW'(push);
        count_d    = clr ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
        state_d    = (recover && !flush_i) ? RECOVER : RUN;
        ex_branch_type_d  = live ? ex_type_i : 2'b00;
        ex_set_register_d = live && ex_link_i && (ex_type_i != 2'b00);
        ex_inst_addr_d    = live ? ex_pc_i : '0;
        redirect_valid_d  = recover && !flush_i;
        redirect_pc_d     = redirect_valid_d ? (ex_taken_i ? ex_target_i : ex_pc_i + AW'(8)) : '0;
        orphan_d          = orphan && !flush_i;
`ifdef BPU_PERF_CNT_EN
        perf_resolve_d    = perf_resolve_q + 32'(pop && !flush_i);
        perf_mispredict_d = perf_mispredict_q + 32'(mispredict && !flush_i);
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]     <= push_pc_i;
            target_mem[wr_ptr_q] <= push_target_i;
            type_mem[wr_ptr_q]   <= push_type_i;
            taken_mem[wr_ptr_q]  <= push_taken_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q           <= RUN;
            rd_ptr_q          <= '0;
            wr_ptr_q          <= '0;
            count_q           <= '0;
            ex_branch_type_q  <= '0;
            ex_set_register_q <= 1'b0;
            ex_inst_addr_q    <= '0;
            redirect_valid_q  <= 1'b0;
            redirect_pc_q     <= '0;
            orphan_q          <= 1'b0;
`ifdef BPU_PERF_CNT_EN
            perf_resolve_q    <= '0;
            perf_mispredict_q <= '0;
`endif
        end else begin
            state_q           <= state_d;
            rd_ptr_q          <= rd_ptr_d;
            wr_ptr_q          <= wr_ptr_d;
            count_q           <= count_d;
            ex_branch_type_q  <= ex_branch_type_d;
            ex_set_register_q <= ex_set_register_d;
            ex_inst_addr_q    <= ex_inst_addr_d;
            redirect_valid_q  <= redirect_valid_d;
            redirect_pc_q     <= redirect_pc_d;
            orphan_q          <= orphan_d;
`ifdef BPU_PERF_CNT_EN
            perf_resolve_q    <= perf_resolve_d;
            perf_mispredict_q <= perf_mispredict_d;
`endif
        end
    end

    assign ex_branch_type_o  = ex_branch_type_q;
    assign ex_set_register_o = ex_set_register_q;
    assign ex_inst_addr_o    = ex_inst_addr_q;
    assign redirect_valid_o  = redirect_valid_q;
    assign redirect_pc_o     = redirect_pc_q;
    assign orphan_o          = orphan_q;
`ifdef BPU_PERF_CNT_EN
    assign perf_resolve_o    = perf_resolve_q;
    assign perf_mispredict_o = perf_mispredict_q;
`endif
endmodule

// File: tb/tb_bpu_resolve_queue.sv
// tb_bpu_resolve_queue: directed vector table plus multi-cycle sequences for bpu_resolve_queue.
module tb_bpu_resolve_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0, push_valid_i = 1'b0, push_ready_o;
    logic [31:0] push_pc_i = '0, push_target_i = '0;
    logic [1:0]  push_type_i = '0;
    logic        push_taken_i = 1'b0;
    logic        ex_valid_i = 1'b0, ex_taken_i = 1'b0, ex_link_i = 1'b0;
    logic [31:0] ex_pc_i = '0, ex_target_i = '0;
    logic [1:0]  ex_type_i = '0;
    logic [1:0]  ex_branch_type_o;
    logic        ex_set_register_o, redirect_valid_o, orphan_o;
    logic [31:0] ex_inst_addr_o, redirect_pc_o;
`ifdef BPU_PERF_CNT_EN
    logic [31:0] perf_resolve_o, perf_mispredict_o;
`endif
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bpu_resolve_queue #(.DEPTH(8), .AW(32)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_pc_i(push_pc_i),
        .push_type_i(push_type_i), .push_taken_i(push_taken_i), .push_target_i(push_target_i),
        .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ex_type_i(ex_type_i), .ex_taken_i(ex_taken_i),
        .ex_target_i(ex_target_i), .ex_link_i(ex_link_i),
`ifdef BPU_PERF_CNT_EN
        .perf_resolve_o(perf_resolve_o), .perf_mispredict_o(perf_mispredict_o),
`endif
        .ex_branch_type_o(ex_branch_type_o), .ex_set_register_o(ex_set_register_o),
        .ex_inst_addr_o(ex_inst_addr_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .orphan_o(orphan_o)
    );

    typedef struct {
        logic fl; logic pv; logic [31:0] ppc; logic [1:0] pty; logic ptk; logic [31:0] ptg;
        logic ev; logic [31:0] epc; logic [1:0] ety; logic etk; logic [31:0] etg; logic elk;
        logic rdy; logic [1:0] bty; logic set; logic [31:0] addr; logic rv; logic [31:0] rpc; logic orph;
    } vec_t;
    vec_t v[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        flush_i = 1'b0; push_valid_i = 1'b0; ex_valid_i = 1'b0; ex_link_i = 1'b0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic [1:0] ty, input logic tk, input logic [31:0] tg);
        push_valid_i = 1'b1; push_pc_i = pc; push_type_i = ty; push_taken_i = tk; push_target_i = tg;
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic [1:0] ty, input logic tk, input logic [31:0] tg);
        ex_valid_i = 1'b1; ex_pc_i = pc; ex_type_i = ty; ex_taken_i = tk; ex_target_i = tg; ex_link_i = 1'b0;
    endtask

    task automatic push1(input logic [31:0] pc);
        set_push(pc, 2'b01, 1'b0, 32'h0);
        step();
        idle();
    endtask

    task automatic pop_ok(input string name, input logic [31:0] pc);
        set_ex(pc, 2'b01, 1'b0, 32'h0);
        step();
        idle();
        chk({name, "_rv"}, 32'(redirect_valid_o), 32'h0);
        chk({name, "_addr"}, ex_inst_addr_o, pc);
    endtask

    initial begin
        v[0]  = '{1'b0, 1'b1, 32'h100, 2'b10, 1'b1, 32'h2008, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0,
                  1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        v[1]  = '{1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 32'h100, 2'b10, 1'b1, 32'h2008, 1'b0,
                  1'b1, 2'b10, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0};
        v[2]  = '{1'b0, 1'b1, 32'h200, 2'b11, 1'b1, 32'h400, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0,
                  1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        v[3]  = '{1'b0, 1'b1, 32'h999, 2'b01, 1'b0, 32'h0, 1'b1, 32'h200, 2'b11, 1'b1, 32'h480, 1'b1,
                  1'b0, 2'b11, 1'b1, 32'h200, 1'b1, 32'h480, 1'b0};
        v[4]  = '{1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 32'h700, 2'b01, 1'b0, 32'h0, 1'b1,
                  1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        v[5]  = '{1'b0, 1'b1, 32'h300, 2'b01, 1'b1, 32'h340, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0,
                  1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        v[6]  = '{1'b0, 1'b1, 32'h888, 2'b01, 1'b0, 32'h0, 1'b1, 32'h300, 2'b01, 1'b0, 32'h0, 1'b0,
                  1'b0, 2'b01, 1'b0, 32'h300, 1'b1, 32'h308, 1'b0};
        v[7]  = '{1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0,
                  1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        v[8]  = '{1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 32'h500, 2'b01, 1'b0, 32'h0, 1'b0,
                  1'b0, 2'b01, 1'b0, 32'h500, 1'b1, 32'h508, 1'b1};
        v[9]  = v[7];
        v[10] = '{1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 32'h600, 2'b00, 1'b1, 32'h640, 1'b1,
                  1'b0, 2'b00, 1'b0, 32'h600, 1'b1, 32'h640, 1'b1};
        v[11] = v[7];

        step();
        step();
        rst = 1'b1;
        chk("reset_ready", 32'(push_ready_o), 32'h1);
        chk("reset_rv", 32'(redirect_valid_o), 32'h0);
        chk("reset_rpc", redirect_pc_o, 32'h0);
        chk("reset_orphan", 32'(orphan_o), 32'h0);
        chk("reset_set", 32'(ex_set_register_o), 32'h0);
        chk("reset_addr", ex_inst_addr_o, 32'h0);

        for (int i = 0; i < 12; i++) begin
            flush_i = v[i].fl;
            push_valid_i = v[i].pv; push_pc_i = v[i].ppc; push_type_i = v[i].pty;
            push_taken_i = v[i].ptk; push_target_i = v[i].ptg;
            ex_valid_i = v[i].ev; ex_pc_i = v[i].epc; ex_type_i = v[i].ety;
            ex_taken_i = v[i].etk; ex_target_i = v[i].etg; ex_link_i = v[i].elk;
            step();
            idle();
            chk($sformatf("v%0d_ready", i), 32'(push_ready_o), 32'(v[i].rdy));
            chk($sformatf("v%0d_btype", i), 32'(ex_branch_type_o), 32'(v[i].bty));
            chk($sformatf("v%0d_set", i), 32'(ex_set_register_o), 32'(v[i].set));
            chk($sformatf("v%0d_addr", i), ex_inst_addr_o, v[i].addr);
            chk($sformatf("v%0d_rv", i), 32'(redirect_valid_o), 32'(v[i].rv));
            chk($sformatf("v%0d_rpc", i), redirect_pc_o, v[i].rpc);
            chk($sformatf("v%0d_orphan", i), 32'(orphan_o), 32'(v[i].orph));
        end

        // Fill to DEPTH, then push against a full queue while popping.
        for (int i = 0; i < 8; i++) begin
            chk("fill_ready", 32'(push_ready_o), 32'h1);
            push1(32'h1000 + 32'(i) * 4);
        end
        chk("full_ready", 32'(push_ready_o), 32'h0);
        set_push(32'hdead, 2'b01, 1'b0, 32'h0);
        pop_ok("full_pop", 32'h1000);
        chk("after_full_pop_ready", 32'(push_ready_o), 32'h1);
        set_push(32'h1020, 2'b01, 1'b0, 32'h0);
        pop_ok("pushpop7", 32'h1004);
        chk("pushpop7_ready", 32'(push_ready_o), 32'h1);
        for (int i = 0; i < 7; i++) pop_ok("drain", 32'h1008 + 32'(i) * 4);
        set_ex(32'h1024, 2'b01, 1'b0, 32'h0);
        step();
        idle();
        chk("drain_orphan", 32'(orphan_o), 32'h1);
        chk("drain_orphan_rpc", redirect_pc_o, 32'h102c);
        step();

        // Pointers wrap more than twice; order must survive.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) push1(32'h4000 + 32'(r) * 32'h100 + 32'(i) * 4);
            for (int i = 0; i < 6; i++) pop_ok("wrap", 32'h4000 + 32'(r) * 32'h100 + 32'(i) * 4);
        end

        // Flush overrides a same-cycle resolve that would otherwise mispredict.
        for (int i = 0; i < 5; i++) push1(32'h5000 + 32'(i) * 4);
        flush_i = 1'b1;
        set_push(32'h5100, 2'b01, 1'b0, 32'h0);
        set_ex(32'h9999, 2'b11, 1'b1, 32'h10);
        ex_link_i = 1'b1;
        step();
        idle();
        chk("flush_rv", 32'(redirect_valid_o), 32'h0);
        chk("flush_orphan", 32'(orphan_o), 32'h0);
        chk("flush_btype", 32'(ex_branch_type_o), 32'h0);
        chk("flush_set", 32'(ex_set_register_o), 32'h0);
        chk("flush_addr", ex_inst_addr_o, 32'h0);
        chk("flush_ready", 32'(push_ready_o), 32'h1);
        set_ex(32'h5000, 2'b01, 1'b0, 32'h0);
        step();
        idle();
        chk("flush_empty_orphan", 32'(orphan_o), 32'h1);
        step();

        // Reset mid-operation drops in-flight records.
        push1(32'h6000);
        push1(32'h6004);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_ready", 32'(push_ready_o), 32'h1);
        set_ex(32'h6000, 2'b01, 1'b0, 32'h0);
        step();
        idle();
        chk("midrst_orphan", 32'(orphan_o), 32'h1);
        step();

`ifdef BPU_PERF_CNT_EN
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("perf_rst_res", perf_resolve_o, 32'h0);
        chk("perf_rst_mis", perf_mispredict_o, 32'h0);
        push1(32'h7000);
        push1(32'h7004);
        pop_ok("perf_pop", 32'h7000);
        set_ex(32'h7004, 2'b01, 1'b1, 32'h7100);
        step();
        idle();
        step();
        set_ex(32'h7200, 2'b01, 1'b0, 32'h0);
        step();
        idle();
        step();
        flush_i = 1'b1;
        step();
        idle();
        chk("perf_res", perf_resolve_o, 32'h2);
        chk("perf_mis", perf_mispredict_o, 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
